// File: rtl/mem_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the MEM-stage
// access controller.
package mem_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] OP_LW  = 3'd0;
  localparam logic [OP_W-1:0] OP_LH  = 3'd1;
  localparam logic [OP_W-1:0] OP_LHU = 3'd2;
  localparam logic [OP_W-1:0] OP_LB  = 3'd3;
  localparam logic [OP_W-1:0] OP_LBU = 3'd4;
  localparam logic [OP_W-1:0] OP_SW  = 3'd5;
  localparam logic [OP_W-1:0] OP_SH  = 3'd6;
  localparam logic [OP_W-1:0] OP_SB  = 3'd7;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd1;
  localparam logic [ST_W-1:0] ST_ACCESS = 3'd2;
  localparam logic [ST_W-1:0] ST_WRITE  = 3'd3;
  localparam logic [ST_W-1:0] ST_RESP   = 3'd4;

  localparam logic [31:0] DM_BYTES_DEF = 32'h3000;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op <= OP_LBU;
  endfunction

  function automatic logic is_sub(input logic [OP_W-1:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (off != 2'd0);
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational little-endian lane logic: load extract/extend and sub-word
// store merge into a full memory word.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [1:0]      off_i,
  input  logic [31:0]     word_i,
  input  logic [15:0]     wdata_i,
  output logic [31:0]     load_c,
  output logic [31:0]     merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    load_c = '0;
    case (op_i)
      OP_LW:   load_c = word_i;
      OP_LH:   load_c = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_c = {16'h0000, half_sel};
      OP_LB:   load_c = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_c = {24'h000000, byte_sel};
      default: load_c = '0;
    endcase

    merge_c = word_i;
    if (op_i == OP_SB) begin
      merge_c[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (op_i == OP_SH) begin
      if (off_i[1]) merge_c[31:16] = wdata_i;
      else          merge_c[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller in front of the word-wide data memory: checks
// requests, drives the dm word port, does read-modify-write for sub-word stores.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 0,
  parameter logic [31:0] DM_BYTES = DM_BYTES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [31:0]     req_pc,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_exc,
  output logic [11:0]     dm_A,
  output logic [31:0]     dm_WD,
  output logic            dm_MemWrite,
  output logic [31:0]     dm_PC,
  input  logic [31:0]     dm_RD
);

  localparam int unsigned CNT_W = 4;

  logic [ST_W-1:0]  state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [13:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pc_q, pc_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      merge_q, merge_d;
  logic [31:0]      result_q, result_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_exc_q, resp_exc_d;
  logic             ready_q, ready_d;
  logic             we_c;
  logic             req_exc_c;
  logic [31:0]      lane_word_c;
  logic [31:0]      load_c;
  logic [31:0]      merge_c;

  assign req_exc_c = misaligned(req_op, req_addr[1:0]) || (req_addr >= DM_BYTES);

  // WRITE merges into the word captured in ACCESS, so dm_WD does not move between them.
  assign lane_word_c = (state_q == ST_WRITE) ? merge_q : dm_RD;

  mem_lane_unit u_lane (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .word_i  (lane_word_c),
    .wdata_i (wdata_q[15:0]),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    exc_d        = exc_q;
    cnt_d        = cnt_q;
    merge_d      = merge_q;
    result_d     = result_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    we_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          addr_d   = req_addr[13:0];
          wdata_d  = req_wdata;
          pc_d     = req_pc;
          exc_d    = req_exc_c;
          cnt_d    = CNT_W'(WAIT_CYC);
          result_d = '0;
          if (req_exc_c)          state_d = ST_RESP;
          else if (WAIT_CYC != 0) state_d = ST_WAIT;
          else                    state_d = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (is_load(op_q)) begin
          result_d = load_c;
          state_d  = ST_RESP;
        end else if (op_q == OP_SW) begin
          we_c    = 1'b1;
          state_d = ST_RESP;
        end else begin
          merge_d = dm_RD;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_c    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = result_q;
        resp_exc_d   = exc_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      exc_q        <= 1'b0;
      cnt_q        <= '0;
      merge_q      <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_exc_q   <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      exc_q        <= exc_d;
      cnt_q        <= cnt_d;
      merge_q      <= merge_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
      ready_q      <= ready_d;
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_exc    = resp_exc_q;
  assign dm_A        = addr_q[13:2];
  assign dm_PC       = pc_q;
  assign dm_WD       = is_sub(op_q) ? merge_c : wdata_q;
  // Reset must kill the strobe immediately, even in the middle of a read-modify-write.
  assign dm_MemWrite = reset & we_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance without wait states, one
// with WAIT_CYC=3, each backed by a small word memory model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_exc;
  logic [31:0] resp_rdata;
  logic [11:0] dm_A;
  logic [31:0] dm_WD, dm_PC, dm_RD;
  logic        dm_MemWrite;

  logic        w_req_valid, w_req_ready;
  logic [2:0]  w_req_op;
  logic [31:0] w_req_addr, w_req_wdata, w_req_pc;
  logic        w_resp_valid, w_resp_exc;
  logic [31:0] w_resp_rdata;
  logic [11:0] w_dm_A;
  logic [31:0] w_dm_WD, w_dm_PC, w_dm_RD;
  logic        w_dm_MemWrite;

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:4095];
  logic        pre1_we, pre2_we;
  logic [11:0] pre1_a, pre2_a;
  logic [31:0] pre1_d, pre2_d;
  int          wr_cnt;
  int          w_wr_cnt;
  int          n_tests;
  int          n_fail;

  mem_access_ctrl #(.WAIT_CYC(0)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_MemWrite(dm_MemWrite), .dm_PC(dm_PC), .dm_RD(dm_RD)
  );

  mem_access_ctrl #(.WAIT_CYC(3)) u_dut_w (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_pc(w_req_pc),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_exc(w_resp_exc),
    .dm_A(w_dm_A), .dm_WD(w_dm_WD), .dm_MemWrite(w_dm_MemWrite), .dm_PC(w_dm_PC), .dm_RD(w_dm_RD)
  );

  assign dm_RD   = mem1[dm_A];
  assign w_dm_RD = mem2[w_dm_A];

  // Memory models: DUT writes take priority over bench preloads.
  always @(posedge clk) begin
    if (dm_MemWrite) begin
      mem1[dm_A] <= dm_WD;
      wr_cnt     <= wr_cnt + 1;
    end else if (pre1_we) begin
      mem1[pre1_a] <= pre1_d;
    end
    if (w_dm_MemWrite) begin
      mem2[w_dm_A] <= w_dm_WD;
      w_wr_cnt     <= w_wr_cnt + 1;
    end else if (pre2_we) begin
      mem2[pre2_a] <= pre2_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pre1(input logic [11:0] a, input logic [31:0] d);
    pre1_we = 1'b1; pre1_a = a; pre1_d = d;
    tick();
    pre1_we = 1'b0;
  endtask

  task automatic pre2(input logic [11:0] a, input logic [31:0] d);
    pre2_we = 1'b1; pre2_a = a; pre2_d = d;
    tick();
    pre2_we = 1'b0;
  endtask

  // Issue one request on the zero-wait instance and check the response.
  task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc,
                         input logic [31:0] exp_rdata, input logic exp_exc, input int exp_lat);
    int lat;
    lat       = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    if (!exp_exc) begin
      chk({tag, ".dm_A"}, 32'(dm_A), 32'(addr[13:2]));
      chk({tag, ".dm_PC"}, dm_PC, pc);
    end
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".exc"}, 32'(resp_exc), 32'(exp_exc));
  endtask

  initial begin
    int w0;
    reset = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_pc = '0;
    w_req_valid = 1'b0; w_req_op = '0; w_req_addr = '0; w_req_wdata = '0; w_req_pc = '0;
    pre1_we = 1'b0; pre1_a = '0; pre1_d = '0;
    pre2_we = 1'b0; pre2_a = '0; pre2_d = '0;
    n_tests = 0; n_fail = 0;

    // Reset state, with preloads done while reset is held
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.exc", 32'(resp_exc), 32'd0);
    chk("rst.memwrite", 32'(dm_MemWrite), 32'd0);
    pre1(12'd4, 32'h8899AABB);
    pre1(12'd8, 32'h11223344);
    pre1(12'd16, 32'hCAFEF00D);
    pre2(12'd0, 32'h0BADF00D);
    reset = 1'b1;
    tick();

    // Loads: lane extraction and extension
    run_req("lb12",  OP_LB,  32'h12, 32'h0, 32'h10, 32'hFFFFFF99, 1'b0, 2);
    run_req("lbu12", OP_LBU, 32'h12, 32'h0, 32'h14, 32'h00000099, 1'b0, 2);
    run_req("lh10",  OP_LH,  32'h10, 32'h0, 32'h18, 32'hFFFFAABB, 1'b0, 2);
    run_req("lhu12", OP_LHU, 32'h12, 32'h0, 32'h1C, 32'h00008899, 1'b0, 2);
    run_req("lw10",  OP_LW,  32'h10, 32'h0, 32'h20, 32'h8899AABB, 1'b0, 2);

    // Sub-word stores via read-modify-write
    w0 = wr_cnt;
    run_req("sb21", OP_SB, 32'h21, 32'h000000EE, 32'h100, 32'h0, 1'b0, 3);
    chk("sb21.wr_cnt", 32'(wr_cnt - w0), 32'd1);
    chk("sb21.mem", mem1[8], 32'h1122EE44);
    run_req("sh22", OP_SH, 32'h22, 32'h0000BEEF, 32'h104, 32'h0, 1'b0, 3);
    chk("sh22.mem", mem1[8], 32'hBEEFEE44);
    run_req("lw20", OP_LW, 32'h20, 32'h0, 32'h108, 32'hBEEFEE44, 1'b0, 2);

    // Exceptions: misaligned and out of range
    w0 = wr_cnt;
    run_req("lw6",    OP_LW, 32'h6,    32'h0,        32'h200, 32'h0, 1'b1, 1);
    run_req("sh3",    OP_SH, 32'h3,    32'h1234,     32'h204, 32'h0, 1'b1, 1);
    run_req("sw3000", OP_SW, 32'h3000, 32'h12345678, 32'h208, 32'h0, 1'b1, 1);
    chk("exc.wr_cnt", 32'(wr_cnt - w0), 32'd0);
    tick();
    chk("exc.pulse", 32'(resp_valid), 32'd0);

    // Reset during WRITE of a byte store drops the write
    w0 = wr_cnt;
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h40; req_wdata = 32'h55; req_pc = 32'h300;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rstw.memwrite", 32'(dm_MemWrite), 32'd0);
    tick();
    reset = 1'b1;
    chk("rstw.ready", 32'(req_ready), 32'd1);
    chk("rstw.resp_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("rstw.resp_valid2", 32'(resp_valid), 32'd0);
    chk("rstw.wr_cnt", 32'(wr_cnt - w0), 32'd0);
    chk("rstw.mem", mem1[16], 32'hCAFEF00D);

    // Back-to-back SW then LW with req_valid held
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h44; req_wdata = 32'hDEADBEEF; req_pc = 32'h400;
    tick();
    req_op = OP_LW; req_wdata = 32'h0; req_pc = 32'h404;
    chk("b2b.ready0", 32'(req_ready), 32'd0);
    tick();
    chk("b2b.ready1", 32'(req_ready), 32'd0);
    chk("b2b.resp1", 32'(resp_valid), 32'd0);
    tick();
    chk("b2b.sw_resp", 32'(resp_valid), 32'd1);
    chk("b2b.sw_rdata", resp_rdata, 32'h0);
    chk("b2b.ready2", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b.lw_accepted", 32'(req_ready), 32'd0);
    begin
      int lat;
      lat = 0;
      while (!resp_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk("b2b.lw_lat", 32'(lat), 32'd2);
    end
    chk("b2b.lw_rdata", resp_rdata, 32'hDEADBEEF);
    chk("b2b.mem", mem1[17], 32'hDEADBEEF);

    // Wait states: WAIT_CYC=3 gives response 5 cycles after accept
    w_req_valid = 1'b1; w_req_op = OP_LW; w_req_addr = 32'h0; w_req_pc = 32'h500;
    tick();
    w_req_valid = 1'b0;
    chk("wait.ready0", 32'(w_req_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        chk($sformatf("wait.resp%0d", k), 32'(w_resp_valid), 32'd0);
        chk($sformatf("wait.ready%0d", k), 32'(w_req_ready), 32'd0);
      end else begin
        chk("wait.resp5", 32'(w_resp_valid), 32'd1);
        chk("wait.rdata", w_resp_rdata, 32'h0BADF00D);
        chk("wait.ready5", 32'(w_req_ready), 32'd1);
      end
      if (k == 3) begin
        chk("wait.dm_A", 32'(w_dm_A), 32'd0);
        chk("wait.dm_PC", w_dm_PC, 32'h500);
        chk("wait.memwrite", 32'(w_dm_MemWrite), 32'd0);
      end
    end
    chk("wait.wr_cnt", 32'(w_wr_cnt), 32'd0);
    chk("wait.wd_idle", 32'(w_dm_WD == 32'h0 ? 1 : 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
